// File: rtl/cache_refill_ctrl.sv
// Lookup/refill controller for a direct-mapped cache: checks one request at a time and
// refills a missed 256-byte line from main memory as LINE_BEATS ascending 32-bit beats.
module cache_refill_ctrl #(
    parameter int LINE_BEATS = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [31:0]      req_addr,
    output logic             req_ready,
    output logic [15:0]      lk_tag,
    output logic [7:0]       lk_index,
    input  logic             hit,
    output logic             mem_rd_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_rd_ack,
    input  logic             mem_rd_valid,
    input  logic [31:0]      mem_rd_data,
    output logic             cache_we,
    output logic [7:0]       cache_index,
    output logic [5:0]       cache_word,
    output logic [31:0]      cache_wdata,
    output logic             tag_we,
    output logic [15:0]      tag_wdata,
    output logic             tag_vwdata,
    output logic             resp_valid,
    output logic             resp_hit,
    input  logic             resp_ready,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MREQ  = 3'd2,
        FILL  = 3'd3,
        TAGWR = 3'd4,
        RESP  = 3'd5
    } state_t;

    localparam logic [5:0] LAST_BEAT = 6'(LINE_BEATS - 1);

    state_t     state;
    logic [5:0] beat;
    logic       fill_wr;

    // The byte offset never matters: the whole line is always fetched.
    logic unused_offset;
    assign unused_offset = ^req_addr[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lk_tag   <= '0;
            lk_index <= '0;
            beat     <= '0;
            resp_hit <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lk_tag   <= req_addr[31:16];
                        lk_index <= req_addr[15:8];
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        resp_hit <= 1'b1;
                        if (hit_cnt != '1)
                            hit_cnt <= hit_cnt + 1'b1;
                        state <= RESP;
                    end else begin
                        if (miss_cnt != '1)
                            miss_cnt <= miss_cnt + 1'b1;
                        state <= MREQ;
                    end
                end
                MREQ: begin
                    if (mem_rd_ack) begin
                        beat  <= '0;
                        state <= FILL;
                    end
                end
                FILL: begin
                    // Hold the counter on the last beat so it can never wrap.
                    if (mem_rd_valid) begin
                        if (beat == LAST_BEAT)
                            state <= TAGWR;
                        else
                            beat <= beat + 1'b1;
                    end
                end
                TAGWR: begin
                    resp_hit <= 1'b0;
                    state    <= RESP;
                end
                RESP: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign mem_rd_req = (state == MREQ);
    assign mem_addr   = {lk_tag, lk_index, 8'h00};
    assign resp_valid = (state == RESP);

    assign fill_wr     = (state == FILL) && mem_rd_valid;
    assign cache_we    = fill_wr;
    assign cache_index = lk_index;
    assign cache_word  = beat;
    assign cache_wdata = fill_wr ? mem_rd_data : 32'h0;

    // A miss invalidates the line in CHECK, so an aborted refill can never look like a hit.
    assign tag_we     = ((state == CHECK) && !hit) || (state == TAGWR);
    assign tag_wdata  = lk_tag;
    assign tag_vwdata = (state == TAGWR);

    a_we_exclusive: assert property (@(posedge clk) !(cache_we && tag_we));

    a_resp_hold: assert property (@(posedge clk) disable iff (rst)
        (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_hit)));

    a_mreq_hold: assert property (@(posedge clk) disable iff (rst)
        (mem_rd_req && !mem_rd_ack) |=> (mem_rd_req && $stable(mem_addr)));

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized scoreboard bench for cache_refill_ctrl with tag-array and memory models.
module tb_cache_refill_ctrl;
    // Narrow counters so saturation is reached in a short run.
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic req_ready;
    logic [15:0] lk_tag;
    logic [7:0] lk_index;
    logic hit;
    logic mem_rd_req;
    logic [31:0] mem_addr;
    logic mem_rd_ack = 1'b0;
    logic mem_rd_valid = 1'b0;
    logic [31:0] mem_rd_data = 32'h0;
    logic cache_we;
    logic [7:0] cache_index;
    logic [5:0] cache_word;
    logic [31:0] cache_wdata;
    logic tag_we;
    logic [15:0] tag_wdata;
    logic tag_vwdata;
    logic resp_valid;
    logic resp_hit;
    logic resp_ready = 1'b0;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    cache_refill_ctrl #(.LINE_BEATS(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .lk_tag(lk_tag), .lk_index(lk_index), .hit(hit),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_ack(mem_rd_ack),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .cache_we(cache_we),
        .cache_index(cache_index), .cache_word(cache_word), .cache_wdata(cache_wdata),
        .tag_we(tag_we), .tag_wdata(tag_wdata), .tag_vwdata(tag_vwdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_ready(resp_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_to(input string name);
        vecs++;
        errs++;
        $display("FAIL %s: timed out waiting for the DUT (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] bdat(input logic [31:0] line, input int w);
        return (line | 32'(w)) ^ 32'h3C5A_0000;
    endfunction

    typedef struct {
        logic [31:0]  addr;
        bit           hit;
        int           lat;
        int           hc;
        int           mc;
        int           delay;
        logic [255:0] pat;
        int           stall;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   inflight = 0;
    bit   seen = 0;
    int   done_cnt = 0, n_issued = 0;
    int   acc_edge = 0, hs_edge = 0;
    int   nwr = 0, ntw = 0, nmreq = 0, nst = 0;

    // Reference cache state and statistics.
    bit        mv[256];
    bit [15:0] mt[256];
    int        mh = 0, mm = 0;

    // Environment tag array, written only by the DUT's tag port; it drives the comparator.
    bit        ev[256];
    bit [15:0] et[256];
    assign hit = ev[lk_index] && (et[lk_index] == lk_tag);

    task automatic issue(input logic [31:0] a, input int d, input int gmode, input int st);
        exp_t e;
        int ones, len, idx;
        bit b;
        idx = int'(a[15:8]);
        e.addr = {a[31:8], 8'h00};
        e.hit = mv[idx] && (mt[idx] == a[31:16]);
        if (e.hit) mh = (mh == CMAX) ? mh : mh + 1;
        else begin
            mm = (mm == CMAX) ? mm : mm + 1;
            mv[idx] = 1'b1;
            mt[idx] = a[31:16];
        end
        e.hc = mh; e.mc = mm; e.delay = d; e.stall = st; e.pat = '0;
        ones = 0; len = 0;
        while (ones < 64) begin
            case (gmode)
                0: b = 1'b1;
                1: b = (len % 3) != 2;
                default: b = ($urandom_range(3) != 0);
            endcase
            if (len > 190) b = 1'b1;
            e.pat[len] = b;
            ones += int'(b);
            len++;
        end
        e.lat = e.hit ? 1 : 67 + d + (len - 64);
        exp_q.push_back(e);
        n_issued++;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr = a;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (req_ready) break;
            if (t > 300) begin fail_to("accept"); break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = $urandom;
    endtask

    task automatic wait_done();
        for (int t = 0; done_cnt < n_issued; t++) begin
            @(negedge clk);
            if (t > 1000) begin fail_to("response"); break; end
        end
    endtask

    // Main-memory model: ack after cur.delay MREQ cycles, then beats gated by cur.pat.
    initial begin : mem_model
        int ph, dc, pp, nb;
        ph = 0; dc = 0; pp = 0; nb = 0;
        forever begin
            @(posedge clk); #1;
            mem_rd_ack = 1'b0;
            mem_rd_valid = 1'b0;
            mem_rd_data = $urandom;
            if (rst) ph = 0;
            else begin
                if (ph == 0 && mem_rd_req) begin ph = 1; dc = 0; end
                if (ph == 1) begin
                    if (dc == cur.delay) begin mem_rd_ack = 1'b1; ph = 2; pp = 0; nb = 0; end
                    else dc++;
                end else if (ph == 2) begin
                    if (cur.pat[pp]) begin
                        mem_rd_valid = 1'b1;
                        mem_rd_data = bdat(cur.addr, nb);
                        nb++;
                    end
                    pp++;
                    if (nb == 64) ph = 0;
                end else begin
                    mem_rd_ack = 1'($urandom_range(1));
                    mem_rd_valid = 1'($urandom_range(1));
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                inflight = 0;
                resp_ready = 1'b0;
                continue;
            end
            if (tag_we) begin
                if (inflight) begin
                    chk("tag_index", 32'(lk_index), 32'(cur.addr[15:8]));
                    chk("tag_wdata", 32'(tag_wdata), 32'(cur.addr[31:16]));
                    chk("tag_vwdata", 32'(tag_vwdata), (ntw == 0) ? 32'd0 : 32'd1);
                    ntw++;
                end
                ev[lk_index] = tag_vwdata;
                et[lk_index] = tag_wdata;
            end
            if (cache_we) begin
                chk("we_overlap", 32'(tag_we), 32'd0);
                if (inflight && nwr < 64) begin
                    chk("cache_index", 32'(cache_index), 32'(cur.addr[15:8]));
                    chk("cache_word", 32'(cache_word), 32'(nwr));
                    chk("cache_wdata", cache_wdata, bdat(cur.addr, nwr));
                end
                nwr++;
            end
            if (mem_rd_req) begin
                chk("mem_addr", mem_addr, cur.addr);
                nmreq++;
            end
            if (resp_valid) begin
                chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                if (!seen) begin
                    seen = 1;
                    chk("latency", 32'(cyc - acc_edge), 32'(cur.lat));
                    chk("resp_hit", 32'(resp_hit), 32'(cur.hit));
                    chk("hit_cnt", 32'(hit_cnt), 32'(cur.hc));
                    chk("miss_cnt", 32'(miss_cnt), 32'(cur.mc));
                end else begin
                    chk("resp_hit_stable", 32'(resp_hit), 32'(cur.hit));
                end
                resp_ready = (nst >= cur.stall);
                if (!resp_ready) nst++;
                else begin
                    chk("n_writes", 32'(nwr), cur.hit ? 32'd0 : 32'd64);
                    chk("n_tag_writes", 32'(ntw), cur.hit ? 32'd0 : 32'd2);
                    chk("mreq_cycles", 32'(nmreq), cur.hit ? 32'd0 : 32'(cur.delay + 1));
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    hs_edge = cyc + 1;
                    done_cnt++;
                    inflight = 0;
                end
            end else begin
                resp_ready = 1'($urandom_range(1));
            end
            if (req_valid && req_ready) begin
                if (exp_q.size() == 0) fail_to("unexpected_accept");
                else cur = exp_q[0];
                acc_edge = cyc + 1;
                inflight = 1; seen = 0;
                nwr = 0; ntw = 0; nmreq = 0; nst = 0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [31:0] a;
        logic [7:0]  ix;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_strobes", {28'h0, mem_rd_req, cache_we, tag_we, resp_valid}, 32'd0);
        chk("rst_resp_hit", 32'(resp_hit), 32'd0);
        chk("rst_lk", {8'h0, lk_tag, lk_index}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_cache_out", {cache_wdata[25:0], cache_word}, 32'd0);
        chk("rst_tag_out", {15'h0, tag_vwdata, tag_wdata}, 32'd0);
        chk("rst_counters", {16'h0, hit_cnt, miss_cnt}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        issue(32'hABCD_1200, 0, 0, 0);       // cold miss, no stalls
        wait_done();
        issue(32'h1234_5678, 0, 0, 0);       // miss, then the same line hits
        issue(32'h1234_5678, 0, 0, 0);
        wait_done();
        issue(32'h5555_3400, 5, 1, 0);       // delayed ack, every third beat missing
        wait_done();

        issue(32'h5555_3410, 0, 0, 10);      // hit held in RESP for 10 cycles
        for (int t = 0; t < 50 && !resp_valid; t++) @(negedge clk);
        if (!resp_valid) fail_to("bp_resp");
        issue(32'hABCD_12FF, 0, 0, 0);
        chk("reaccept_edge", 32'(acc_edge), 32'(hs_edge + 1));
        wait_done();

        for (int i = 0; i < 450; i++) begin
            case ($urandom_range(3))
                0: ix = 8'h12;
                1: ix = 8'h34;
                2: ix = 8'h56;
                default: ix = 8'h9A;
            endcase
            a = {((ix == 8'h9A) && $urandom_range(1) == 1) ? 16'h5A5A : 16'hABCD,
                 ix, 8'($urandom_range(255))};
            issue(a, $urandom_range(3), $urandom_range(2), $urandom_range(2));
            wait_done();
        end
        chk("hit_cnt_saturated", 32'(hit_cnt), 32'(mh));
        chk("miss_cnt_final", 32'(miss_cnt), 32'(mm));

        issue(32'h7777_EE00, 0, 0, 0);       // reset during the fill
        for (int t = 0; nwr < 10; t++) begin
            @(negedge clk);
            if (t > 200) begin fail_to("fill_progress"); break; end
        end
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        n_issued = done_cnt;
        mh = 0; mm = 0; mv[8'hEE] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_strobes", {28'h0, mem_rd_req, cache_we, tag_we, resp_valid}, 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_counters", {16'h0, hit_cnt, miss_cnt}, 32'd0);
        chk("mid_rst_line_invalid", 32'(ev[8'hEE]), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        issue(32'h7777_EE00, 1, 2, 1);       // must miss again after the abort
        wait_done();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Sequential lookup/refill controller for the direct-mapped cache (32-bit byte address, 16-bit tag, 8-bit index, 8-bit byte offset, 256-byte lines). It accepts one processor request at a time and samples the tag comparator's hit result. On a miss it fetches the full line from main memory as 64 32-bit beats, writes them into the cache data array, and then writes the new tag and valid bit. It sits between the request port, the tag/data arrays and the main-memory read port.

## Interface
- LINE_BEATS, 64: 32-bit beats per 256-byte line.
- CNT_W, 16: width of the hit and miss statistics counters.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_addr  input  32  byte address: tag = [31:16], index = [15:8], offset = [7:0].
- req_ready  output  1  controller can accept a request.
- lk_tag  output  16  latched tag, driven to the comparator.
- lk_index  output  8  latched index, driven to the tag array read port.
- hit  input  1  comparator result (tag match AND valid); meaningful in CHECK only.
- mem_rd_req  output  1  line read request to main memory.
- mem_addr  output  32  line-aligned address {tag, index, 8'h00}.
- mem_rd_ack  input  1  memory has accepted the request.
- mem_rd_valid  input  1  one beat of read data is present.
- mem_rd_data  input  32  beat data; beats arrive in ascending word order.
- cache_we  output  1  data-array write strobe.
- cache_index  output  8  data-array line.
- cache_word  output  6  word within the line.
- cache_wdata  output  32  data to write.
- tag_we  output  1  tag-array write strobe.
- tag_wdata  output  16  tag to write.
- tag_vwdata  output  1  valid bit to write.
- resp_valid  output  1  response present.
- resp_hit  output  1  1 = hit, 0 = serviced miss.
- resp_ready  input  1  consumer accepts the response.
- hit_cnt  output  CNT_W  saturating count of hits.
- miss_cnt  output  CNT_W  saturating count of misses.

## Operation
The controller is a single FSM with six states: IDLE, CHECK, MREQ, FILL, TAGWR and RESP.

- **IDLE:** req_ready = 1.
  - When req_valid is high, latch req_addr into lk_tag and lk_index, then go to CHECK.
- **CHECK:** lasts exactly one cycle. Sample hit.
  - hit = 1: increment hit_cnt, set resp_hit = 1, go to RESP.
  - hit = 0: in this same cycle drive tag_we = 1, tag_wdata = lk_tag, tag_vwdata = 0, which invalidates the line before it is overwritten. Increment miss_cnt, go to MREQ.
- **MREQ:** hold mem_rd_req = 1 and a stable mem_addr until mem_rd_ack is seen, then clear the beat counter and go to FILL.
  - A mem_rd_ack that arrives in the first MREQ cycle is honoured.
- **FILL:** on each cycle where mem_rd_valid = 1, drive:
  - cache_we = 1
  - cache_index = lk_index
  - cache_word = beat counter
  - cache_wdata = mem_rd_data
  
  Then increment the beat counter. Gaps in mem_rd_valid stall the fill and produce no write. When the beat at counter = LINE_BEATS-1 is written, go to TAGWR.
- **TAGWR:** one cycle with tag_we = 1, tag_wdata = lk_tag, tag_vwdata = 1. Set resp_hit = 0 and go to RESP.
- **RESP:** resp_valid = 1, with resp_hit held stable. When resp_ready is high, go to IDLE. A new request is accepted no earlier than the following cycle.

General rules:
- mem_rd_valid outside FILL is ignored.
- mem_rd_ack outside MREQ is ignored.
- The beat counter is 6 bits wide and is never allowed to wrap inside FILL.
- hit_cnt and miss_cnt saturate at all-ones and do not wrap.
- cache_we and tag_we are never high in the same cycle.

## Timing
- **Reset:** forces IDLE. Reset values:
  - req_ready = 1.
  - mem_rd_req, cache_we, tag_we, resp_valid, resp_hit = 0.
  - lk_tag, lk_index, mem_addr, cache_word, cache_wdata, tag_wdata, tag_vwdata = 0.
  - hit_cnt, miss_cnt = 0; beat counter = 0.
- **Reset mid-operation:** when rst is asserted in any state, every strobe is 0 from the next edge.
  - The line was already invalidated in CHECK, so an aborted fill leaves an invalid line and is never seen as a false hit.
- **Hit latency:** request accepted at edge N; CHECK occupies cycle N+1; resp_valid is first high in cycle N+2.
- **Miss latency:** with ack in the first MREQ cycle and no data gaps:
  - CHECK: 1 cycle.
  - MREQ: 1 cycle.
  - FILL: 64 cycles.
  - TAGWR: 1 cycle.
  - resp_valid is first high 68 cycles after the accept edge.
- **Strobe registration:** strobes are combinational decodes of the registered state and counters. They are valid in the same cycle as the state that produces them.
- **Back-pressure:** if resp_ready is held low, RESP holds indefinitely with resp_valid and resp_hit stable.

## Test plan
- **Reset:** assert rst for 2 cycles in FILL at beat 10 -> all strobes 0 on the next edge, req_ready = 1, both counters 0.
- **Hit:** req_addr = 32'h1234_5678 with hit = 1 in CHECK -> resp_valid at accept+2, resp_hit = 1, hit_cnt = 1, no mem_rd_req, no tag_we.
- **Miss:** req_addr = 32'hABCD_1200 with hit = 0 -> tag_we with tag_vwdata = 0 in CHECK; mem_addr = 32'hABCD_1200. With data = beat number, 64 writes occur to index 8'h12 with words 0..63. Then tag_we with tag_wdata = 16'hABCD and tag_vwdata = 1. Finally resp_hit = 0, miss_cnt = 1, total 68 cycles.
- **Stalls:** ack delayed 5 cycles and mem_rd_valid low every third cycle -> exactly 64 cache_we pulses, each word written once in order, resp_valid delayed by the stall cycles.
- **Back-pressure:** resp_ready held low for 10 cycles -> resp_valid held, req_ready = 0, a new req_valid is not accepted until the cycle after the resp_ready handshake.
- **Saturation:** preload, or run 65 535 hits, then one more hit -> hit_cnt stays at 16'hFFFF.
